// File: rtl/mux_arbiter_2req.sv
// Round-robin two-requester arbiter owning a registered 2:1 mux.
// Ports: clk, reset (sync, active-high); req_a/req_b with data a/b in;
//   gnt_a/gnt_b (registered, never both), sel (1=a), y/y_valid (registered);
//   preempt_cnt (8-bit saturating) only when MUX_ARB_STATS_EN is defined.
module mux_arbiter_2req #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [7:0]       preempt_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_e;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             last_a_q, last_a_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             enter;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // last owner loses a tie
        if (req_a && req_b)
          state_d = last_a_q ? OWN_B : OWN_A;
        else if (req_a)
          state_d = OWN_A;
        else if (req_b)
          state_d = OWN_B;
      end
      OWN_A: begin
        if (!req_a)
          state_d = req_b ? OWN_B : IDLE;
        else if (req_b && hold_q == HOLD_LIM)
          state_d = OWN_B;
      end
      OWN_B: begin
        if (!req_b)
          state_d = req_a ? OWN_A : IDLE;
        else if (req_a && hold_q == HOLD_LIM)
          state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enter    = (state_d != IDLE) && (state_d != state_q);
    hold_d   = hold_q;
    last_a_d = last_a_q;
    if (enter) begin
      hold_d   = 8'd0;
      last_a_d = (state_d == OWN_A);
    end else if (state_d != IDLE && hold_q != HOLD_LIM) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_comb begin
    sel_d     = sel_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (state_d == OWN_A)
      sel_d = 1'b1;
    else if (state_d == OWN_B)
      sel_d = 1'b0;
    if (state_d != IDLE) begin
      y_d       = sel_d ? a : b;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      last_a_q  <= 1'b0;
      sel_q     <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_a_q  <= last_a_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt_a   = (state_q == OWN_A);
  assign gnt_b   = (state_q == OWN_B);
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

`ifdef MUX_ARB_STATS_EN
  logic [7:0] preempt_cnt_q, preempt_cnt_d;
  logic       preempt;

  // only contention at the hold limit counts, not voluntary drops
  always_comb begin
    preempt = req_a && req_b && hold_q == HOLD_LIM &&
              (state_q == OWN_A || state_q == OWN_B);
    preempt_cnt_d = preempt_cnt_q;
    if (preempt && preempt_cnt_q != 8'hff)
      preempt_cnt_d = preempt_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      preempt_cnt_q <= 8'd0;
    else
      preempt_cnt_q <= preempt_cnt_d;
  end

  assign preempt_cnt = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arbiter_2req.sv
// Scoreboard bench for mux_arbiter_2req (WIDTH=1, MAX_HOLD=4).
// Expected outputs are predicted at drive time, checked after the edge.
module tb_mux_arbiter_2req;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [0:0] a = '0, b = '0;
  logic gnt_a, gnt_b, sel, y_valid;
  logic [0:0] y;
`ifdef MUX_ARB_STATS_EN
  logic [7:0] preempt_cnt;
`endif

  mux_arbiter_2req #(.WIDTH(1), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b),
    .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .sel(sel), .y(y), .y_valid(y_valid)
`ifdef MUX_ARB_STATS_EN
    , .preempt_cnt(preempt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {gnt_a, gnt_b, sel, y, y_valid}
  logic [4:0] sb[$];
  logic [4:0] exp_v, obs_v;

  // reference model state: own 0=idle 1=A 2=B
  int m_own = 0, m_hold = 0, m_pc = 0;
  bit m_last_a = 0, m_sel = 0, m_y = 0, m_v = 0;

  task automatic drive(input bit r, input bit ra, input bit rb,
                       input bit da, input bit db);
    int nxt;
    reset = r; req_a = ra; req_b = rb; a = da; b = db;
    if (r) begin
      m_own = 0; m_hold = 0; m_last_a = 0;
      m_sel = 0; m_y = 0; m_v = 0; m_pc = 0;
    end else begin
      nxt = m_own;
      if (m_own == 0) begin
        if (ra && rb) nxt = m_last_a ? 2 : 1;
        else if (ra) nxt = 1;
        else if (rb) nxt = 2;
      end else if (m_own == 1) begin
        if (!ra) nxt = rb ? 2 : 0;
        else if (rb && m_hold == MH - 1) begin
          nxt = 2;
          if (m_pc < 255) m_pc++;
        end
      end else begin
        if (!rb) nxt = ra ? 1 : 0;
        else if (ra && m_hold == MH - 1) begin
          nxt = 1;
          if (m_pc < 255) m_pc++;
        end
      end
      if (nxt != 0 && nxt != m_own) begin
        m_hold = 0;
        m_last_a = (nxt == 1);
      end else if (nxt != 0 && m_hold < MH - 1) begin
        m_hold++;
      end
      m_own = nxt;
      if (nxt == 1) m_sel = 1;
      if (nxt == 2) m_sel = 0;
      m_v = (nxt != 0);
      if (nxt != 0) m_y = m_sel ? da : db;
    end
    sb.push_back({m_own == 1, m_own == 2, m_sel, m_y, m_v});
    @(posedge clk);
    #1;
    obs_v = {gnt_a, gnt_b, sel, y[0], y_valid};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 1, 0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v || obs_v !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_hold%0d got=%b want=%b", i, obs_v, exp_v);
      end
    end
    drive(0, 1, 1, 1, 0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== 5'b10111) begin
      n_err++;
      $display("FAIL reset_release got=%b want=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_sole_a();
    int pat[4] = '{1, 0, 1, 1};
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, pat[i % 4][0], 0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v || gnt_a !== 1'b1 || gnt_b !== 1'b0 ||
          y[0] !== pat[i % 4][0]) begin
        n_err++;
        $display("FAIL sole_a c%0d got=%b want=%b", i, obs_v, exp_v);
      end
    end
`ifdef MUX_ARB_STATS_EN
    n_cmp++;
    if (preempt_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL sole_a_pcnt got=%0d want=0", preempt_cnt);
    end
`endif
  endtask

  task automatic test_contention();
    bit want_a;
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 1, 1, 0);
      exp_v = sb.pop_front();
      want_a = ((i / 4) % 2) == 0;
      n_cmp++;
      if (obs_v !== exp_v || gnt_a !== want_a || y[0] !== want_a) begin
        n_err++;
        $display("FAIL contend c%0d got=%b want=%b", i, obs_v, exp_v);
      end
    end
`ifdef MUX_ARB_STATS_EN
    n_cmp++;
    if (preempt_cnt !== 8'd3) begin
      n_err++;
      $display("FAIL contend_pcnt got=%0d want=3", preempt_cnt);
    end
`endif
  endtask

  task automatic test_handover();
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(0, 1, 0, 1, 0);
    void'(sb.pop_front());
    drive(0, 1, 1, 1, 0);
    void'(sb.pop_front());
    drive(0, 0, 1, 0, 1);
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== 5'b01011) begin
      n_err++;
      $display("FAIL handover got=%b want=%b", obs_v, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 1, 1);
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v || gnt_a !== (i == 3)) begin
        n_err++;
        $display("FAIL handover_hold c%0d got=%b want=%b",
                 i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(0, 1, 1, 1, 1);
    void'(sb.pop_front());
    drive(0, 0, 1, 1, 1);
    void'(sb.pop_front());
    drive(1, 1, 1, 1, 1);
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_mid got=%b want=%b", obs_v, exp_v);
    end
    drive(0, 1, 1, 1, 0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== 5'b10111) begin
      n_err++;
      $display("FAIL reset_mid_rel got=%b want=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_idle_hold();
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(0, 0, 1, 0, 1);
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== 5'b01011) begin
      n_err++;
      $display("FAIL idle_own_b got=%b want=%b", obs_v, exp_v);
    end
    drive(0, 0, 0, 0, 0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs_v !== exp_v || obs_v !== 5'b00010) begin
      n_err++;
      $display("FAIL idle_hold got=%b want=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_random();
    bit r;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 39) == 0);
      drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs_v !== exp_v || (gnt_a & gnt_b)) begin
        n_err++;
        $display("FAIL random c%0d got=%b want=%b", i, obs_v, exp_v);
      end
    end
`ifdef MUX_ARB_STATS_EN
    n_cmp++;
    if (preempt_cnt !== 8'(m_pc)) begin
      n_err++;
      $display("FAIL random_pcnt got=%0d want=%0d", preempt_cnt, m_pc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sole_a();
    test_contention();
    test_handover();
    test_reset_mid();
    test_idle_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
